store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 32, word address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 WE  input  1  CPU store request this cycle.
REQ-007 WA  input  ADDR_W  CPU store address.
REQ-008 WD  input  DATA_W  CPU store data.
REQ-009 RE  input  1  CPU load request this cycle.
REQ-010 RA  input  ADDR_W  CPU load address.
REQ-011 DataRD  output  DATA_W  load data returned to CPU, combinational.
REQ-012 stall  output  1  CPU must hold its request and retry next cycle.
REQ-013 mem_addr  output  ADDR_W  shared data-memory address.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 mem_wd  output  DATA_W  data-memory write data.
REQ-016 mem_rd  input  DATA_W  data-memory combinational read data.
REQ-017 empty  output  1  no buffered stores; count == 0.

Function
REQ-018 Buffer SHALL be a FIFO of DEPTH {addr, data, valid} entries with head/tail pointers and a count of 0..DEPTH.
REQ-019 drain SHALL be count>0 && (!RE || count==DEPTH); the memory port is single, so loads take priority unless full.
REQ-020 On drain: mem_we=1, mem_addr=head.addr, mem_wd=head.data; head entry retires at the edge; otherwise mem_we=0, mem_addr=RA.
REQ-021 hit SHALL be WE matching a valid entry's address, excluding the head entry when drain is 1.
REQ-022 WE && hit && !stall SHALL overwrite that entry's data in place (coalesce); count unchanged.
REQ-023 WE && !hit && !stall SHALL enqueue {WA, WD} at tail.
REQ-024 stall SHALL be count==DEPTH && ((WE && !hit) || RE); a stalled request has no effect on state.
REQ-025 Enqueue and drain in one cycle SHALL leave count unchanged; full-stall cycle drains, so next cycle count==DEPTH-1.
REQ-026 At most one valid entry SHALL hold any address (guaranteed by REQ-022).
REQ-027 RE && !stall: if RA matches a valid entry, DataRD = that entry's data, else DataRD = mem_rd.
REQ-028 A store in the same cycle as a load to the same address SHALL NOT forward; the load sees pre-cycle contents.
REQ-029 A load matching the head entry while it drains (full case) is stalled, so no forwarding race exists.
REQ-030 When RE=0, DataRD SHALL equal mem_rd.
REQ-031 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-032 Stores SHALL reach memory in program order except coalesced overwrites, which keep the original slot.

Reset
REQ-033 rst_n low SHALL immediately clear all valid bits, head, tail, count; buffered stores are discarded.
REQ-034 During and after reset until a store arrives: mem_we=0, stall=0, empty=1, mem_addr=RA.
REQ-035 Reset deassertion SHALL be synchronized by the integrator; block takes no action on release edge.

Structure
REQ-036 ADDR_W/DATA_W defaults and the entry record type SHALL live in the shared mips_pkg package.
REQ-037 Address match logic SHALL be one sub-module sb_match: DEPTH-way compare returning hit flag and one-hot index.
REQ-038 Block SHALL insert between mips and data_memory ports without changing either.

Verification
REQ-039 Reset, three stores 0x10/0x14/0x18 with RE=0 -> mem_we on three consecutive cycles after enqueue, program order, empty=1 after.
REQ-040 DEPTH=4, RE=1 held, five stores -> stall on fifth, one drain that cycle, fifth accepted next cycle.
REQ-041 Store 0x20=0xAAAA then 0x20=0xBBBB while RE blocks drain -> count 1, memory later written 0xBBBB once.
REQ-042 Store 0x30=0x1234 buffered, load 0x30 -> DataRD=0x1234 same cycle; load 0x34 -> DataRD=mem_rd.
REQ-043 Same-cycle store 0x40=0x5 and load 0x40 with memory holding 0x9 -> DataRD=0x9; next load -> 0x5.
REQ-044 rst_n low with three entries buffered -> count 0, empty 1, no mem_we for discarded stores.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS data-side path. Holds the
//                default word address/data widths and the store-buffer entry
//                record used by the core, the store buffer and data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Default word address and data widths of the data-memory port.
    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

    // One buffered store: a pending write of data to a word address.
    typedef struct packed {
        logic                valid;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_match.sv
`default_nettype none
// ============================================================================
//  Module      : sb_match
//  Description : DEPTH-way associative address compare for the store buffer.
//                Every valid entry's address is compared with a key. Returns
//                a hit flag and the one-hot index of the matching entry. The
//                buffer never holds two valid entries with the same address,
//                so the index has at most one bit set.
//  Ports       : i_addr   - entry addresses, one word per entry
//                i_valid  - per-entry enable (valid bit, optionally masked)
//                i_key    - address to look up
//                o_hit    - some enabled entry matches i_key
//                o_onehot - one bit per entry, set on match
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_match
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [ADDR_W-1:0]            i_key,
    output logic                         o_hit,
    output logic [DEPTH-1:0]             o_onehot
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign o_onehot[gi] = i_valid[gi] && (i_addr[gi] == i_key);
    end

    assign o_hit = |o_onehot;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Write-coalescing store buffer between the MIPS core data
//                port and a single-ported data memory. CPU stores are queued
//                in a FIFO and drained to memory on cycles where the core is
//                not loading (or whenever the buffer is full). Stores to an
//                address already buffered overwrite that entry in place.
//                Loads that hit a buffered address are forwarded from it.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                WE, WA, WD        - CPU store request / address / data
//                RE, RA            - CPU load request / address
//                DataRD            - load data to CPU (combinational)
//                stall             - CPU must hold its request and retry
//                mem_addr, mem_we,
//                mem_wd            - data-memory address / write en / data
//                mem_rd            - data-memory read data (combinational)
//                empty             - no stores are buffered
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,          // power of two, 2..16
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RA,
    output logic [DATA_W-1:0] DataRD,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              empty
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [DEPTH-1:0]   c_ONE_1H  = DEPTH'(1);

    // ------------------------------------------------------------------
    // Entry storage and FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [DEPTH-1:0]             r_valid;
    logic [c_PTR_W-1:0]           r_head;
    logic [c_PTR_W-1:0]           r_tail;
    logic [c_PTR_W:0]             r_count;

    logic                         w_full;
    logic                         w_drain;
    logic [DEPTH-1:0]             w_head_1h;
    logic [DEPTH-1:0]             w_st_valid;
    logic                         w_st_match;
    logic [DEPTH-1:0]             w_st_1h;
    logic                         w_st_hit;
    logic                         w_ld_hit;
    logic [DEPTH-1:0]             w_ld_1h;
    logic                         w_coalesce;
    logic                         w_enq;
    logic [DATA_W-1:0]            w_fwd_data;

    assign w_full  = (r_count == c_FULL);
    assign empty   = (r_count == '0);

    // The memory port is shared: a load owns it unless the buffer is full,
    // in which case the load is stalled and the oldest store drains.
    assign w_drain = !empty && (!RE || w_full);

    // The head entry retires this edge when draining, so a store to the
    // same address must not merge into it; it becomes a new entry instead.
    assign w_head_1h  = c_ONE_1H << r_head;
    assign w_st_valid = r_valid & ~(w_drain ? w_head_1h : '0);

    sb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_st_match (
        .i_addr   (r_addr),
        .i_valid  (w_st_valid),
        .i_key    (WA),
        .o_hit    (w_st_match),
        .o_onehot (w_st_1h)
    );

    sb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ld_match (
        .i_addr   (r_addr),
        .i_valid  (r_valid),
        .i_key    (RA),
        .o_hit    (w_ld_hit),
        .o_onehot (w_ld_1h)
    );

    assign w_st_hit   = WE && w_st_match;
    assign stall      = w_full && ((WE && !w_st_hit) || RE);
    assign w_coalesce = w_st_hit && !stall;
    assign w_enq      = WE && !w_st_hit && !stall;

    // ------------------------------------------------------------------
    // Load forwarding: reads pre-edge contents, so a store issued in the
    // same cycle is not visible to the load.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ld_1h[i]) begin
                w_fwd_data = w_fwd_data | r_data[i];
            end
        end
    end

    assign DataRD   = (RE && !stall && w_ld_hit) ? w_fwd_data : mem_rd;

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------
    assign mem_we   = w_drain;
    assign mem_addr = w_drain ? r_addr[r_head] : RA;
    assign mem_wd   = w_drain ? r_data[r_head] : '0;

    // ------------------------------------------------------------------
    // Control state: valid bits, pointers, occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Drain and enqueue never touch the same slot: enqueue cannot
            // happen when full, and drain cannot happen when empty.
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_ONE;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry payload: qualified by the valid bits, so no reset is needed.
    // A coalesced store keeps its original slot and thus its drain order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= WA;
            r_data[r_tail] <= WD;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_coalesce && w_st_1h[i]) begin
                r_data[i] <= WD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. A table of directed
//                vectors with hand-derived expectations, an asynchronous
//                reset sequence, and randomized traffic compared against a
//                queue-based reference model of the buffer and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WE, RE;
    logic [31:0] WA, WD, RA;
    logic [31:0] DataRD, mem_addr, mem_wd, mem_rd;
    logic        stall, mem_we, empty;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .WE       (WE),
        .WA       (WA),
        .WD       (WD),
        .RE       (RE),
        .RA       (RA),
        .DataRD   (DataRD),
        .stall    (stall),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .empty    (empty)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'h9 : (32'hC000_0000 | 32'(i));
    endfunction

    // Data memory seen by the DUT: 64 words, combinational read.
    logic [31:0] tmem [64];
    assign mem_rd = tmem[mem_addr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) tmem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_we) tmem[mem_addr[7:2]] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: program-ordered queue of pending stores + memory
    // ------------------------------------------------------------------
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [31:0] refmem [64];

    typedef struct {
        logic we; logic [31:0] wa; logic [31:0] wd; logic re; logic [31:0] ra;
        logic x_stall; logic x_we; logic [31:0] x_addr; logic [31:0] x_wd;
        logic [31:0] x_rd; logic chk_rd; logic x_empty;
    } vec_t;

    function automatic vec_t V(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                               input logic re, input logic [31:0] ra,
                               input logic xs, input logic xw, input logic [31:0] xa,
                               input logic [31:0] xd, input logic [31:0] xr,
                               input logic chk, input logic xe);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.x_stall = xs; v.x_we = xw; v.x_addr = xa; v.x_wd = xd;
        v.x_rd = xr; v.chk_rd = chk; v.x_empty = xe;
        return v;
    endfunction

    function automatic void model_eval(input vec_t v,
            output logic e_stall, output logic e_drain, output logic [31:0] e_addr,
            output logic [31:0] e_wd, output logic [31:0] e_rd, output logic e_empty,
            output int e_hit);
        int  n  = q.size();
        int  ld = -1;
        logic full = (n == DEPTH);
        e_drain = (n > 0) && (!v.re || full);
        e_hit = -1;
        if (v.we)
            for (int i = (e_drain ? 1 : 0); i < n; i++)
                if (q[i].a == v.wa) e_hit = i;
        e_stall = full && ((v.we && e_hit < 0) || v.re);
        e_addr  = e_drain ? q[0].a : v.ra;
        e_wd    = e_drain ? q[0].d : 32'h0;
        if (v.re && !e_stall) begin
            for (int i = 0; i < n; i++) if (q[i].a == v.ra) ld = i;
            e_rd = (ld >= 0) ? q[ld].d : refmem[v.ra[7:2]];
        end else begin
            e_rd = refmem[e_addr[7:2]];
        end
        e_empty = (n == 0);
    endfunction

    function automatic void model_commit(input vec_t v, input logic e_stall,
                                         input logic e_drain, input int e_hit);
        ent_t e;
        if (!e_stall && e_hit >= 0) q[e_hit].d = v.wd;
        if (e_drain) begin
            refmem[q[0].a[7:2]] = q[0].d;
            void'(q.pop_front());
        end
        if (v.we && !e_stall && e_hit < 0) begin
            e.a = v.wa; e.d = v.wd;
            q.push_back(e);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check 1 ns later, then advance
    // the model to its post-edge state.
    task automatic step(input vec_t v, input bit use_model, input string tag);
        logic        e_stall, e_drain, e_empty, chk;
        logic [31:0] e_addr, e_wd, e_rd;
        int          e_hit;
        @(negedge clk);
        WE = v.we; WA = v.wa; WD = v.wd; RE = v.re; RA = v.ra;
        #1;
        model_eval(v, e_stall, e_drain, e_addr, e_wd, e_rd, e_empty, e_hit);
        if (use_model) begin
            check({tag, " stall"},    32'(stall),  32'(e_stall));
            check({tag, " mem_we"},   32'(mem_we), 32'(e_drain));
            check({tag, " mem_addr"}, mem_addr,    e_addr);
            if (e_drain) check({tag, " mem_wd"}, mem_wd, e_wd);
            check({tag, " empty"},    32'(empty),  32'(e_empty));
            chk = !(v.re && e_stall);
            if (chk) check({tag, " DataRD"}, DataRD, e_rd);
        end else begin
            check({tag, " stall"},    32'(stall),  32'(v.x_stall));
            check({tag, " mem_we"},   32'(mem_we), 32'(v.x_we));
            check({tag, " mem_addr"}, mem_addr,    v.x_addr);
            if (v.x_we) check({tag, " mem_wd"}, mem_wd, v.x_wd);
            check({tag, " empty"},    32'(empty),  32'(v.x_empty));
            if (v.chk_rd) check({tag, " DataRD"}, DataRD, v.x_rd);
        end
        model_commit(v, e_stall, e_drain, e_hit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tab[$];

    initial begin
        int re_pct;
        vec_t v;
        for (int i = 0; i < 64; i++) refmem[i] = init_val(i);

        // -------------------- reset state --------------------
        rst_n = 1'b0; WE = 1'b0; WA = '0; WD = '0; RE = 1'b0; RA = 32'h44;
        #1;
        check("reset empty",    32'(empty),  32'h1);
        check("reset mem_we",   32'(mem_we), 32'h0);
        check("reset stall",    32'(stall),  32'h0);
        check("reset mem_addr", mem_addr,    32'h44);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // -------------------- directed table --------------------
        // in-order drain of three stores with RE low
        tab.push_back(V(1,'h10,'h111,0,0, 0,0,'h00,0,'hC000_0000,1,1));
        tab.push_back(V(1,'h14,'h222,0,0, 0,1,'h10,'h111,'hC000_0004,1,0));
        tab.push_back(V(1,'h18,'h333,0,0, 0,1,'h14,'h222,'hC000_0005,1,0));
        tab.push_back(V(0,0,0,0,0,        0,1,'h18,'h333,'hC000_0006,1,0));
        tab.push_back(V(0,0,0,0,0,        0,0,'h00,0,'hC000_0000,1,1));
        // coalescing while loads hold the port
        tab.push_back(V(1,'h20,'hAAAA,1,'h80, 0,0,'h80,0,'hC000_0020,1,1));
        tab.push_back(V(1,'h20,'hBBBB,1,'h20, 0,0,'h20,0,'hAAAA,1,0));
        tab.push_back(V(0,0,0,1,'h20,         0,0,'h20,0,'hBBBB,1,0));
        tab.push_back(V(0,0,0,0,0,            0,1,'h20,'hBBBB,'hC000_0008,1,0));
        tab.push_back(V(0,0,0,0,0,            0,0,'h00,0,'hC000_0000,1,1));
        // forwarding hit and miss
        tab.push_back(V(1,'h30,'h1234,0,0, 0,0,'h00,0,'hC000_0000,1,1));
        tab.push_back(V(0,0,0,1,'h30,      0,0,'h30,0,'h1234,1,0));
        tab.push_back(V(0,0,0,1,'h34,      0,0,'h34,0,'hC000_000D,1,0));
        tab.push_back(V(0,0,0,0,0,         0,1,'h30,'h1234,'hC000_000C,1,0));
        // same-cycle store and load do not forward
        tab.push_back(V(1,'h40,'h5,1,'h40, 0,0,'h40,0,'h9,1,1));
        tab.push_back(V(0,0,0,1,'h40,      0,0,'h40,0,'h5,1,0));
        tab.push_back(V(0,0,0,0,0,         0,1,'h40,'h5,'h9,1,0));
        tab.push_back(V(0,0,0,0,0,         0,0,'h00,0,'hC000_0000,1,1));
        // fill under continuous loads, stall on the fifth store
        tab.push_back(V(1,'h50,'hD1,1,'hC0, 0,0,'hC0,0,'hC000_0030,1,1));
        tab.push_back(V(1,'h54,'hD2,1,'hC0, 0,0,'hC0,0,'hC000_0030,1,0));
        tab.push_back(V(1,'h58,'hD3,1,'hC0, 0,0,'hC0,0,'hC000_0030,1,0));
        tab.push_back(V(1,'h5C,'hD4,1,'hC0, 0,0,'hC0,0,'hC000_0030,1,0));
        tab.push_back(V(1,'h60,'hD5,1,'hC0, 1,1,'h50,'hD1,0,0,0));
        tab.push_back(V(1,'h60,'hD5,1,'hC0, 0,0,'hC0,0,'hC000_0030,1,0));
        tab.push_back(V(0,0,0,0,0,          0,1,'h54,'hD2,'hC000_0015,1,0));
        tab.push_back(V(0,0,0,0,0,          0,1,'h58,'hD3,'hC000_0016,1,0));
        tab.push_back(V(0,0,0,0,0,          0,1,'h5C,'hD4,'hC000_0017,1,0));
        tab.push_back(V(0,0,0,0,0,          0,1,'h60,'hD5,'hC000_0018,1,0));
        tab.push_back(V(0,0,0,0,0,          0,0,'h00,0,'hC000_0000,1,1));
        for (int i = 0; i < tab.size(); i++)
            step(tab[i], 1'b0, $sformatf("vec%0d", i));

        // -------------------- asynchronous reset with stores held --------------------
        for (int i = 0; i < 3; i++)
            step(V(1, 32'h70 + 32'(4*i), 32'hE0 + 32'(i), 1, 32'hF0, 0,0,0,0,0,0,0), 1'b1, "rst_fill");
        @(negedge clk);
        WE = 1'b0; RE = 1'b0; RA = 32'h8;
        #1;
        check("pre_rst mem_we", 32'(mem_we), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst empty",    32'(empty),  32'h1);
        check("rst mem_we",   32'(mem_we), 32'h0);
        check("rst stall",    32'(stall),  32'h0);
        check("rst mem_addr", mem_addr,    32'h8);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            step(V(0,0,0,0,32'h8, 0,0,0,0,0,0,0), 1'b1, "post_rst");

        // -------------------- randomized traffic vs model --------------------
        re_pct = 20;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) re_pct = (re_pct == 20) ? 85 : 20;
            v = V(($urandom_range(0, 99) < 60), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                  $urandom, ($urandom_range(0, 99) < re_pct),
                  {25'h0, 5'($urandom_range(0, 31)), 2'b00}, 0,0,0,0,0,0,0);
            step(v, 1'b1, $sformatf("rnd%0d", c));
        end

        // drain remaining stores, bounded
        for (int c = 0; c < 8; c++)
            step(V(0,0,0,0,0, 0,0,0,0,0,0,0), 1'b1, "drain");
        check("final model empty", 32'(q.size()), 32'h0);
        check("final dut empty",   32'(empty),    32'h1);
        @(negedge clk);
        for (int i = 0; i < 64; i++)
            check($sformatf("mem[%0d]", i), tmem[i], refmem[i]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
